// File: rtl/fp_div_pkg.sv
// Shared types and constant builders for the iterative FP divider and its siblings.
package fp_div_pkg;

    typedef enum logic [1:0] {StIdle, StDivide, StNorm, StDone} state_e;

    typedef enum logic [2:0] {ClsZero, ClsNormal, ClsInf, ClsQnan, ClsSnan} op_class_e;

    localparam int unsigned FLG_INV = 4;
    localparam int unsigned FLG_DZ  = 3;
    localparam int unsigned FLG_OF  = 2;
    localparam int unsigned FLG_UF  = 1;
    localparam int unsigned FLG_NX  = 0;

    // Builders return a wide vector; callers size-cast to their own operand width.
    localparam int unsigned FP_MAX_W = 64;

    function automatic logic [FP_MAX_W-1:0] fp_zero(input int unsigned exp_w,
                                                    input int unsigned man_w,
                                                    input logic sign);
        return FP_MAX_W'(sign) << (exp_w + man_w);
    endfunction

    function automatic logic [FP_MAX_W-1:0] fp_inf(input int unsigned exp_w,
                                                   input int unsigned man_w,
                                                   input logic sign);
        logic [FP_MAX_W-1:0] ones;
        ones = (FP_MAX_W'(1) << exp_w) - FP_MAX_W'(1);
        return (ones << man_w) | fp_zero(exp_w, man_w, sign);
    endfunction

    function automatic logic [FP_MAX_W-1:0] fp_qnan(input int unsigned exp_w,
                                                    input int unsigned man_w);
        return fp_inf(exp_w, man_w, 1'b0) | (FP_MAX_W'(1) << (man_w - 1));
    endfunction

endpackage

// File: rtl/fp_div_classify.sv
// Operand classification and special-case resolution for division (denormals flush to zero).
module fp_div_classify
    import fp_div_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic [EXP_W+MAN_W:0] a_op,
    input  logic [EXP_W+MAN_W:0] b_op,
    output logic                 special,
    output logic [EXP_W+MAN_W:0] special_result,
    output logic [4:0]           special_flags
);

    localparam int unsigned W = 1 + EXP_W + MAN_W;

    function automatic op_class_e classify_op(input logic [EXP_W-1:0] e,
                                              input logic [MAN_W-1:0] m);
        if (e == '0) return ClsZero;
        if (e != '1) return ClsNormal;
        if (m == '0) return ClsInf;
        return m[MAN_W-1] ? ClsQnan : ClsSnan;
    endfunction

    op_class_e cls_a, cls_b;
    logic      sign;
    logic      nan_a, nan_b;

    assign cls_a = classify_op(a_op[W-2:MAN_W], a_op[MAN_W-1:0]);
    assign cls_b = classify_op(b_op[W-2:MAN_W], b_op[MAN_W-1:0]);
    assign sign  = a_op[W-1] ^ b_op[W-1];
    assign nan_a = (cls_a == ClsQnan) || (cls_a == ClsSnan);
    assign nan_b = (cls_b == ClsQnan) || (cls_b == ClsSnan);

    always_comb begin
        special        = 1'b1;
        special_result = W'(fp_zero(EXP_W, MAN_W, sign));
        special_flags  = '0;
        if (nan_a || nan_b) begin
            special_result         = W'(fp_qnan(EXP_W, MAN_W));
            special_flags[FLG_INV] = (cls_a == ClsSnan) || (cls_b == ClsSnan);
        end else if ((cls_a == ClsZero && cls_b == ClsZero) ||
                     (cls_a == ClsInf && cls_b == ClsInf)) begin
            special_result         = W'(fp_qnan(EXP_W, MAN_W));
            special_flags[FLG_INV] = 1'b1;
        end else if (cls_a == ClsInf) begin
            special_result = W'(fp_inf(EXP_W, MAN_W, sign));
        end else if (cls_b == ClsInf) begin
            special_result = W'(fp_zero(EXP_W, MAN_W, sign));
        end else if (cls_b == ClsZero) begin
            special_result        = W'(fp_inf(EXP_W, MAN_W, sign));
            special_flags[FLG_DZ] = 1'b1;
        end else if (cls_a == ClsZero) begin
            special_result = W'(fp_zero(EXP_W, MAN_W, sign));
        end else begin
            special = 1'b0;
        end
    end

endmodule

// File: rtl/fp_divider_iter.sv
// Iterative IEEE-754 divider: radix-2 restoring mantissa division, one quotient bit per clock,
// round-to-nearest-even, valid/ready on both sides.
module fp_divider_iter
    import fp_div_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a_op,
    input  logic [EXP_W+MAN_W:0] b_op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic [4:0]           flags
);

    localparam int unsigned W     = 1 + EXP_W + MAN_W;
    localparam int unsigned CNT_W = $clog2(MAN_W + 3);
    localparam int unsigned SE_W  = EXP_W + 2;

    typedef logic signed [SE_W-1:0] sexp_t;

    localparam sexp_t            BIAS     = sexp_t'((1 << (EXP_W - 1)) - 1);
    localparam sexp_t            EXP_MAX  = sexp_t'((1 << EXP_W) - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAN_W + 2);

    state_e state_q, state_d;

    logic             accept;
    logic             special;
    logic [W-1:0]     special_result;
    logic [4:0]       special_flags;

    logic             sign_q;
    logic [EXP_W-1:0] ea_q, eb_q;
    logic [MAN_W+1:0] rem_q;
    logic [MAN_W:0]   mb_q;
    logic [MAN_W+2:0] q_q;
    logic [CNT_W-1:0] cnt_q;
    logic [W-1:0]     result_q;
    logic [4:0]       flags_q;

    fp_div_classify #(
        .EXP_W(EXP_W),
        .MAN_W(MAN_W)
    ) u_classify (
        .a_op          (a_op),
        .b_op          (b_op),
        .special       (special),
        .special_result(special_result),
        .special_flags (special_flags)
    );

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (accept) state_d = special ? StDone : StDivide;
            StDivide: if (cnt_q == CNT_LAST) state_d = StNorm;
            StNorm:   state_d = StDone;
            StDone:   if (out_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
    end

    // Restoring step: remainder stays below 2*mb, so one extra bit covers the trial borrow.
    logic [MAN_W+2:0] trial;
    logic             q_bit;
    logic [MAN_W+1:0] rem_keep;

    always_comb begin
        trial    = {1'b0, rem_q} - {2'b00, mb_q};
        q_bit    = ~trial[MAN_W+2];
        rem_keep = q_bit ? trial[MAN_W+1:0] : rem_q;
    end

    sexp_t            exp_pre, exp_fin;
    logic [MAN_W-1:0] frac;
    logic [MAN_W:0]   frac_sum;
    logic             guard, sticky, round_up;
    logic [W-1:0]     norm_result;
    logic [4:0]       norm_flags;

    always_comb begin
        exp_pre = sexp_t'({2'b00, ea_q}) - sexp_t'({2'b00, eb_q}) + BIAS;
        if (q_q[MAN_W+2]) begin
            frac   = q_q[MAN_W+1:2];
            guard  = q_q[1];
            sticky = q_q[0] | (rem_q != '0);
        end else begin
            frac    = q_q[MAN_W:1];
            guard   = q_q[0];
            sticky  = (rem_q != '0);
            exp_pre = exp_pre - sexp_t'(1);
        end
        round_up = guard & (sticky | frac[0]);
        // Carry out of the fraction means the rounded mantissa became 2.0.
        frac_sum = {1'b0, frac} + {{MAN_W{1'b0}}, round_up};
        exp_fin  = exp_pre + sexp_t'(frac_sum[MAN_W]);

        norm_flags         = '0;
        norm_flags[FLG_NX] = guard | sticky;
        if (exp_fin >= EXP_MAX) begin
            norm_result        = W'(fp_inf(EXP_W, MAN_W, sign_q));
            norm_flags[FLG_OF] = 1'b1;
            norm_flags[FLG_NX] = 1'b1;
        end else if (exp_fin <= sexp_t'(0)) begin
            norm_result        = W'(fp_zero(EXP_W, MAN_W, sign_q));
            norm_flags[FLG_UF] = 1'b1;
            norm_flags[FLG_NX] = 1'b1;
        end else begin
            norm_result = {sign_q, exp_fin[EXP_W-1:0], frac_sum[MAN_W-1:0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_q   <= 1'b0;
            ea_q     <= '0;
            eb_q     <= '0;
            rem_q    <= '0;
            mb_q     <= '0;
            q_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        sign_q <= a_op[W-1] ^ b_op[W-1];
                        ea_q   <= a_op[W-2:MAN_W];
                        eb_q   <= b_op[W-2:MAN_W];
                        rem_q  <= {2'b01, a_op[MAN_W-1:0]};
                        mb_q   <= {1'b1, b_op[MAN_W-1:0]};
                        q_q    <= '0;
                        cnt_q  <= '0;
                        if (special) begin
                            result_q <= special_result;
                            flags_q  <= special_flags;
                        end
                    end
                end
                StDivide: begin
                    q_q   <= {q_q[MAN_W+1:0], q_bit};
                    rem_q <= rem_keep << 1;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                StNorm: begin
                    result_q <= norm_result;
                    flags_q  <= norm_flags;
                end
                default: ;
            endcase
        end
    end

    assign result = result_q;
    assign flags  = flags_q;

endmodule

// File: tb/tb_fp_divider_iter.sv
// Directed bench for fp_divider_iter (single precision); latency counts the accepting edge as 1.
module tb_fp_divider_iter;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [31:0] a_op      = '0;
    logic [31:0] b_op      = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic [4:0]  flags;

    int unsigned passed = 0;
    int unsigned total  = 0;

    fp_divider_iter #(
        .EXP_W(8),
        .MAN_W(23)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_op     (a_op),
        .b_op     (b_op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .flags    (flags)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    endtask

    // Accept one operation, wait (bounded) for out_valid, check it, then drain.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input logic [4:0] flg, input int lat);
        int edges;
        check({tag, ".ready"}, 32'(in_ready), 32'd1);
        a_op     = a;
        b_op     = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        edges    = 1;
        while (!out_valid && edges < 64) begin
            tick();
            edges++;
        end
        check({tag, ".lat"}, 32'(edges), 32'(lat));
        check({tag, ".result"}, result, res);
        check({tag, ".flags"}, 32'(flags), 32'(flg));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, ".drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int edges;

        #12;
        check("rst.ready", 32'(in_ready), 32'd1);
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.result", result, 32'h0);
        check("rst.flags", 32'(flags), 32'h0);
        #5 rst = 1'b0;
        tick();

        run_op("six_div_three", 32'h40C00000, 32'h40400000, 32'h40000000, 5'b00000, 28);
        run_op("one_div_three", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 28);
        run_op("neg_one_div_three", 32'hBF800000, 32'h40400000, 32'hBEAAAAAB, 5'b00001, 28);
        run_op("one_div_zero", 32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000, 1);
        run_op("zero_div_zero", 32'h00000000, 32'h00000000, 32'h7FC00000, 5'b10000, 1);
        run_op("snan_div_one", 32'h7F800001, 32'h3F800000, 32'h7FC00000, 5'b10000, 1);
        run_op("ninf_div_two", 32'hFF800000, 32'h40000000, 32'hFF800000, 5'b00000, 1);
        run_op("two_div_inf", 32'h40000000, 32'h7F800000, 32'h00000000, 5'b00000, 1);
        run_op("overflow", 32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 5'b00101, 28);
        run_op("underflow", 32'h00800000, 32'h40000000, 32'h00000000, 5'b00011, 28);

        // Backpressure: result held, no second accept while in DONE.
        a_op     = 32'h40C00000;
        b_op     = 32'h40400000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        edges    = 1;
        while (!out_valid && edges < 64) begin
            tick();
            edges++;
        end
        check("bp.lat", 32'(edges), 32'd28);
        a_op     = 32'h3F800000;
        b_op     = 32'h40400000;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp.result", result, 32'h40000000);
            check("bp.flags", 32'(flags), 32'h0);
            check("bp.in_ready", 32'(in_ready), 32'd0);
            check("bp.valid", 32'(out_valid), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp.release_valid", 32'(out_valid), 32'd0);
        check("bp.release_result", result, 32'h40000000);
        run_op("back_to_back", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 28);

        // Asynchronous reset in the middle of DIVIDE.
        a_op     = 32'h40C00000;
        b_op     = 32'h40400000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        check("mid.busy", 32'(in_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst.valid", 32'(out_valid), 32'd0);
        check("mid_rst.result", result, 32'h0);
        check("mid_rst.ready", 32'(in_ready), 32'd1);
        check("mid_rst.flags", 32'(flags), 32'h0);
        #2 rst = 1'b0;
        tick();
        run_op("post_rst", 32'h40C00000, 32'h40400000, 32'h40000000, 5'b00000, 28);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
